// File: rtl/ycocg_fade_out.sv
// Pixel back end: frame-stepped luma fade, 6-stage YCoCg->RGB conversion, clamp, scale, de blanking.
// Sync, de and coordinates travel alongside the colour data so every output is exactly 6 cycles late.
module ycocg_fade_out #(
  parameter int CORDW      = 11,
  parameter int YW         = 7,
  parameter int CW         = 8,
  parameter int OUTW       = 8,
  parameter int FADE_SHIFT = 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic [CORDW-1:0]        in_sx,
  input  logic [CORDW-1:0]        in_sy,
  input  logic                    in_de,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic [YW-1:0]           in_y,
  input  logic signed [CW-1:0]    in_co,
  input  logic signed [CW-1:0]    in_cg,
  input  logic                    frame,
  input  logic                    fade_start,
  input  logic [1:0]              fade_cmd,
  output logic                    fade_busy,
  output logic [YW:0]             fade_level,
  output logic [1:0]              fade_state,
  output logic [CORDW-1:0]        sx,
  output logic [CORDW-1:0]        sy,
  output logic                    de,
  output logic                    hsync,
  output logic                    vsync,
  output logic [OUTW-1:0]         r,
  output logic [OUTW-1:0]         g,
  output logic [OUTW-1:0]         b
);
  localparam int IW   = YW + 3;
  localparam int MW   = 2 * CORDW + 3;
  localparam int DIVW = (FADE_SHIFT > 0) ? FADE_SHIFT : 1;
  localparam logic [YW:0]            AMAX    = {1'b1, {YW{1'b0}}};
  localparam logic [DIVW-1:0]        DIV_MAX = DIVW'((2 ** FADE_SHIFT) - 1);
  localparam logic signed [IW-1:0]   VMAX    = IW'((1 << YW) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FADE_OUT = 2'd1, FADE_IN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [YW:0]     a_q, a_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            busy_q;

  // Fade controller: a command in the same cycle as a frame pulse takes priority.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    div_d   = div_q;
    if (fade_start && fade_cmd == 2'b11) begin
      state_d = IDLE;
      a_d     = '0;
      div_d   = '0;
    end else if (fade_start && fade_cmd == 2'b01 && state_q == IDLE) begin
      if (a_q != AMAX) begin
        state_d = FADE_OUT;
        div_d   = '0;
      end
    end else if (fade_start && fade_cmd == 2'b10 && state_q == IDLE) begin
      if (a_q != '0) begin
        state_d = FADE_IN;
        div_d   = '0;
      end
    end else if (frame && state_q != IDLE) begin
      if (div_q == DIV_MAX) begin
        div_d = '0;
        a_d   = (state_q == FADE_OUT) ? a_q + 1'b1 : a_q - 1'b1;
        if (a_d == AMAX || a_d == '0) state_d = IDLE;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= IDLE;
      a_q     <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      div_q   <= div_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign fade_busy  = busy_q;
  assign fade_level = a_q;
  assign fade_state = state_q;

  function automatic logic [YW-1:0] clamp_y(input logic signed [IW-1:0] v);
    if (v < 0) return '0;
    else if (v > VMAX) return '1;
    else return v[YW-1:0];
  endfunction

  // MSB replication so that 0 maps to 0 and full scale maps to all ones.
  function automatic logic [OUTW-1:0] scale_c(input logic [YW-1:0] v);
    logic [OUTW-1:0] w;
    w = OUTW'(v);
    return (w << (OUTW - YW)) | (w >> (2 * YW - OUTW));
  endfunction

  logic signed [IW-1:0] ydiff, ye1_d;
  logic signed [IW-1:0] ye1_q, co1_q, cg1_q;
  logic signed [IW-1:0] t2_q, co2_q, cg2_q;
  logic signed [IW-1:0] g3_q, b3_q, co3_q;
  logic signed [IW-1:0] r4_q, g4_q, b4_q;
  logic [OUTW-1:0]      r5_q, g5_q, b5_q;
  logic [OUTW-1:0]      r6_q, g6_q, b6_q;
  logic [4:0]           blank_q;
  logic [MW-1:0]        meta_q [6];

  always_comb begin
    ydiff = $signed({3'b000, in_y}) - $signed({2'b00, a_q});
    ye1_d = ydiff[IW-1] ? '0 : ydiff;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      ye1_q <= '0; co1_q <= '0; cg1_q <= '0;
      t2_q  <= '0; co2_q <= '0; cg2_q <= '0;
      g3_q  <= '0; b3_q  <= '0; co3_q <= '0;
      r4_q  <= '0; g4_q  <= '0; b4_q  <= '0;
      r5_q  <= '0; g5_q  <= '0; b5_q  <= '0;
      r6_q  <= '0; g6_q  <= '0; b6_q  <= '0;
      blank_q <= '0;
      for (int i = 0; i < 6; i++) meta_q[i] <= '0;
    end else begin
      ye1_q <= ye1_d;
      co1_q <= IW'(in_co);
      cg1_q <= IW'(in_cg);
      t2_q  <= ye1_q - (cg1_q >>> 1);
      co2_q <= co1_q;
      cg2_q <= cg1_q;
      g3_q  <= cg2_q + t2_q;
      b3_q  <= t2_q - (co2_q >>> 1);
      co3_q <= co2_q;
      r4_q  <= b3_q + co3_q;
      g4_q  <= g3_q;
      b4_q  <= b3_q;
      r5_q  <= scale_c(clamp_y(r4_q));
      g5_q  <= scale_c(clamp_y(g4_q));
      b5_q  <= scale_c(clamp_y(b4_q));
      r6_q  <= blank_q[4] ? '0 : r5_q;
      g6_q  <= blank_q[4] ? '0 : g5_q;
      b6_q  <= blank_q[4] ? '0 : b5_q;
      // Blank decision uses the attenuation seen by this pixel at stage 1.
      blank_q <= {blank_q[3:0], (!in_de || a_q == AMAX)};
      meta_q[0] <= {in_sx, in_sy, in_de, in_hsync, in_vsync};
      for (int i = 1; i < 6; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  assign {sx, sy, de, hsync, vsync} = meta_q[5];
  assign r = r6_q;
  assign g = g6_q;
  assign b = b6_q;
endmodule

// File: tb/tb_ycocg_fade_out.sv
// Bench for ycocg_fade_out: random pixel stream and fade commands checked against an arithmetic model.
module tb_ycocg_fade_out;
  localparam int CORDW = 11, YW = 7, CW = 8, OUTW = 8, FS = 1;
  localparam int AMAX = 1 << YW;
  localparam int MW = 2 * CORDW + 3;
  localparam int EW = 3 * OUTW + MW;

  logic clk_pix, rst_pix;
  logic [CORDW-1:0] in_sx, in_sy;
  logic in_de, in_hsync, in_vsync;
  logic [YW-1:0] in_y;
  logic [CW-1:0] in_co, in_cg;
  logic frame, fade_start;
  logic [1:0] fade_cmd;
  logic fade_busy;
  logic [YW:0] fade_level;
  logic [1:0] fade_state;
  logic [CORDW-1:0] sx, sy;
  logic de, hsync, vsync;
  logic [OUTW-1:0] r, g, b;

  ycocg_fade_out #(.CORDW(CORDW), .YW(YW), .CW(CW), .OUTW(OUTW), .FADE_SHIFT(FS)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .in_sx(in_sx), .in_sy(in_sy), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_y(in_y), .in_co(in_co), .in_cg(in_cg),
    .frame(frame), .fade_start(fade_start), .fade_cmd(fade_cmd), .fade_busy(fade_busy),
    .fade_level(fade_level), .fade_state(fade_state), .sx(sx), .sy(sy), .de(de),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b)
  );

  // clock / reset
  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  int total_cnt = 0;
  int bad_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: fade level as a frame-counting state, pixels as integer arithmetic
  int m_lvl, m_mode, m_fcnt;  // m_mode: 0 idle, 1 fading out, 2 fading in
  logic [EW-1:0] exp_q[$];
  bit hold_en;
  logic [YW-1:0] hold_y;
  logic [CW-1:0] hold_co, hold_cg;

  function automatic void model_reset();
    m_lvl = 0; m_mode = 0; m_fcnt = 0;
  endfunction

  function automatic void model_step(input bit start, input logic [1:0] cmd, input bit frm);
    if (start && cmd == 2'b11) begin
      m_lvl = 0; m_mode = 0; m_fcnt = 0;
    end else if (start && cmd == 2'b01 && m_mode == 0 && m_lvl < AMAX) begin
      m_mode = 1; m_fcnt = 0;
    end else if (start && cmd == 2'b10 && m_mode == 0 && m_lvl > 0) begin
      m_mode = 2; m_fcnt = 0;
    end else if (frm && m_mode != 0) begin
      m_fcnt++;
      if (m_fcnt == (1 << FS)) begin
        m_fcnt = 0;
        m_lvl += (m_mode == 1) ? 1 : -1;
        if (m_lvl == AMAX || m_lvl == 0) m_mode = 0;
      end
    end
  endfunction

  function automatic int to_out(input int v);
    int c;
    c = (v < 0) ? 0 : ((v > AMAX - 1) ? AMAX - 1 : v);
    return c * (1 << (OUTW - YW)) + c / (1 << (2 * YW - OUTW));
  endfunction

  function automatic logic [3*OUTW-1:0] model_rgb(input int y, input int co, input int cg,
                                                  input int lvl, input bit de_in);
    int ye, t, gv, bv, rv;
    logic [OUTW-1:0] ro, go, bo;
    if (!de_in || lvl == AMAX) return '0;
    ye = (y > lvl) ? y - lvl : 0;
    t  = ye - (cg >>> 1);
    gv = cg + t;
    bv = t - (co >>> 1);
    rv = bv + co;
    ro = OUTW'(to_out(rv)); go = OUTW'(to_out(gv)); bo = OUTW'(to_out(bv));
    return {ro, go, bo};
  endfunction

  // driver: one clock of stimulus, model update and output check
  task automatic tick(input bit start, input logic [1:0] cmd, input bit frm);
    logic [EW-1:0] e;
    if (hold_en) begin
      in_y = hold_y; in_co = hold_co; in_cg = hold_cg; in_de = 1'b1;
    end else begin
      in_y  = YW'($urandom_range(0, AMAX - 1));
      in_co = CW'($urandom_range(0, 255));
      in_cg = CW'($urandom_range(0, 255));
      in_de = ($urandom_range(0, 3) != 0);
    end
    in_sx = CORDW'($urandom_range(0, 2047));
    in_sy = CORDW'($urandom_range(0, 2047));
    in_hsync = 1'($urandom_range(0, 1));
    in_vsync = 1'($urandom_range(0, 1));
    fade_start = start; fade_cmd = cmd; frame = frm;
    e = {model_rgb(int'(in_y), int'($signed(in_co)), int'($signed(in_cg)), m_lvl, in_de),
         in_sx, in_sy, in_de, in_hsync, in_vsync};
    exp_q.push_back(e);
    @(posedge clk_pix);
    if (rst_pix) begin
      model_reset();
      exp_q = {};
      repeat (5) exp_q.push_back('0);
    end else begin
      model_step(start, cmd, frm);
    end
    #1;
    if (rst_pix) begin
      check_eq("reset_out", {r, g, b, sx, sy, de, hsync, vsync}, '0);
    end else if (exp_q.size() == 6) begin
      e = exp_q.pop_front();
      check_eq("r", r, e[EW-1 -: OUTW]);
      check_eq("g", g, e[EW-OUTW-1 -: OUTW]);
      check_eq("b", b, e[MW +: OUTW]);
      check_eq("sync_coord", {sx, sy, de, hsync, vsync}, e[MW-1:0]);
    end
    check_eq("fade_level", fade_level, m_lvl);
    check_eq("fade_busy", fade_busy, m_mode != 0);
    check_eq("fade_state", fade_state, m_mode);
    fade_start = 1'b0; frame = 1'b0;
  endtask

  task automatic run_frames(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 2'b00, 1'b1);
      repeat (gap - 1) tick(1'b0, 2'b00, 1'b0);
    end
  endtask

  task automatic hold_pixel(input logic [YW-1:0] y, input logic [CW-1:0] co, input logic [CW-1:0] cg,
                            input logic [OUTW-1:0] er, input logic [OUTW-1:0] eg,
                            input logic [OUTW-1:0] eb, input string tag);
    hold_en = 1'b1; hold_y = y; hold_co = co; hold_cg = cg;
    repeat (7) tick(1'b0, 2'b00, 1'b0);
    check_eq({tag, "_r"}, r, er);
    check_eq({tag, "_g"}, g, eg);
    check_eq({tag, "_b"}, b, eb);
    hold_en = 1'b0;
  endtask

  initial begin
    rst_pix = 1'b1; frame = 1'b0; fade_start = 1'b0; fade_cmd = 2'b00; hold_en = 1'b0;
    in_sx = '0; in_sy = '0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    in_y = '0; in_co = '0; in_cg = '0; hold_y = '0; hold_co = '0; hold_cg = '0;
    model_reset();
    repeat (5) exp_q.push_back('0);

    // reset with random inputs
    repeat (3) tick(1'b0, 2'b00, 1'b0);
    rst_pix = 1'b0;
    repeat (200) tick(1'b0, 2'b00, 1'b0);

    // colour conversion corners
    hold_pixel(7'd64, 8'h00, 8'h00, 8'h81, 8'h81, 8'h81, "mid_grey");
    hold_pixel(7'd127, 8'h7f, 8'h00, 8'hff, 8'hff, 8'h81, "red_clamp");
    hold_pixel(7'd0, 8'h00, 8'h80, 8'h81, 8'h00, 8'h81, "neg_cg");

    // full fade-out to black
    tick(1'b1, 2'b01, 1'b0);
    check_eq("fo_busy", fade_busy, 1'b1);
    run_frames(2 * AMAX, 3);
    check_eq("fo_done_level", fade_level, AMAX);
    check_eq("fo_done_busy", fade_busy, 1'b0);
    hold_pixel(7'd127, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "black");

    // fade-in with start and frame in the same cycle
    tick(1'b1, 2'b10, 1'b1);
    check_eq("fi_start_level", fade_level, AMAX);
    run_frames(1, 3);
    check_eq("fi_first_frame", fade_level, AMAX);
    run_frames(1, 3);
    check_eq("fi_second_frame", fade_level, AMAX - 1);
    run_frames(2 * AMAX - 2, 3);
    check_eq("fi_done_level", fade_level, 0);
    check_eq("fi_done_busy", fade_busy, 1'b0);
    tick(1'b1, 2'b10, 1'b0);
    check_eq("fi_noop_busy", fade_busy, 1'b0);

    // mid-fade command handling and reset
    tick(1'b1, 2'b01, 1'b0);
    run_frames(80, 3);
    check_eq("mid_level", fade_level, 40);
    tick(1'b1, 2'b01, 1'b0);
    check_eq("mid_ignore_level", fade_level, 40);
    check_eq("mid_ignore_busy", fade_busy, 1'b1);
    tick(1'b1, 2'b11, 1'b0);
    check_eq("snap_level", fade_level, 0);
    check_eq("snap_busy", fade_busy, 1'b0);
    tick(1'b1, 2'b01, 1'b0);
    run_frames(80, 3);
    rst_pix = 1'b1;
    tick(1'b0, 2'b00, 1'b0);
    rst_pix = 1'b0;
    check_eq("rst_mid_level", fade_level, 0);
    check_eq("rst_mid_busy", fade_busy, 1'b0);

    // random mix of pixels, frames, commands and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit st, fr;
      st = ($urandom_range(0, 29) == 0);
      fr = !st && ($urandom_range(0, 2) == 0);
      rst_pix = ($urandom_range(0, 799) == 0);
      tick(st, 2'($urandom_range(0, 3)), fr);
    end
    rst_pix = 1'b0;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
